gate_truth_checker: RTL and testbench

- Sequential stimulus/checker stage for the 2-input logic-gate library. It sits directly upstream of a gate under test and drives the gate's in1/in2.
- It also consumes the gate's out and compares it against a parameterised 4-entry truth table.
- It reports per-vector mismatches and a pass/fail verdict, so gate blocks (NOR, AND, OR, ...) self-check in hardware instead of needing manual waveform inspection.

---
 rtl/gate_truth_checker.sv | 146 ++++++++++++++
 tb/tb_gate_truth_checker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// Drives all four input vectors into a 2-input gate under test and compares
// the gate's output with a truth table, reporting per-vector mismatches and a verdict.
module gate_truth_checker #(
  parameter logic [3:0]  EXPECTED      = 4'b0001,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       in1,
  output logic       in2,
  input  logic       dut_out,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] fail_count
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             in1_nxt, in2_nxt;
  logic [1:0]       vec_idx_nxt;
  logic             busy_nxt, done_nxt, pass_nxt;
  logic [3:0]       fail_mask_nxt;
  logic [2:0]       fail_count_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             mism;
  logic [3:0]       mask_upd;

  // Case-inequality so an unknown gate output is scored as a mismatch
  always_comb begin
    mism     = (dut_out !== EXPECTED[vec_idx]);
    mask_upd = fail_mask | (4'(mism) << vec_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in1        <= 1'b0;
      in2        <= 1'b0;
      vec_idx    <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_mask  <= 4'd0;
      fail_count <= 3'd0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      in1        <= in1_nxt;
      in2        <= in2_nxt;
      vec_idx    <= vec_idx_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      fail_mask  <= fail_mask_nxt;
      fail_count <= fail_count_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    in1_nxt        = in1;
    in2_nxt        = in2;
    vec_idx_nxt    = vec_idx;
    busy_nxt       = busy;
    done_nxt       = done;
    pass_nxt       = pass;
    fail_mask_nxt  = fail_mask;
    fail_count_nxt = fail_count;
    cnt_nxt        = cnt;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt      = DRIVE;
          in1_nxt        = 1'b0;
          in2_nxt        = 1'b0;
          vec_idx_nxt    = 2'd0;
          busy_nxt       = 1'b1;
          done_nxt       = 1'b0;
          pass_nxt       = 1'b0;
          fail_mask_nxt  = 4'd0;
          fail_count_nxt = 3'd0;
        end
      end
      DRIVE: begin
        cnt_nxt   = SETTLE_LOAD;
        state_nxt = (SETTLE_LOAD == '0) ? SAMPLE : SETTLE;
      end
      SETTLE: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        fail_mask_nxt  = mask_upd;
        fail_count_nxt = fail_count + 3'(mism);
        if (vec_idx != 2'd3) begin
          vec_idx_nxt          = vec_idx + 2'd1;
          {in1_nxt, in2_nxt}   = vec_idx + 2'd1;
          state_nxt            = DRIVE;
        end else begin
          state_nxt   = DONE;
          busy_nxt    = 1'b0;
          done_nxt    = 1'b1;
          pass_nxt    = (mask_upd == 4'd0);
          in1_nxt     = 1'b0;
          in2_nxt     = 1'b0;
          vec_idx_nxt = 2'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Abort beats any same-cycle sample and discards partial results
    if (abort && busy) begin
      state_nxt      = IDLE;
      in1_nxt        = 1'b0;
      in2_nxt        = 1'b0;
      vec_idx_nxt    = 2'd0;
      busy_nxt       = 1'b0;
      done_nxt       = 1'b0;
      pass_nxt       = 1'b0;
      fail_mask_nxt  = 4'd0;
      fail_count_nxt = 3'd0;
      cnt_nxt        = '0;
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (default and zero-settle/AND table)
// each driving a truth-table gate model; results checked against table arithmetic.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start_v [2];
  logic       abort_v [2];
  logic       in1_v   [2];
  logic       in2_v   [2];
  logic       dout_v  [2];
  logic [1:0] vec_v   [2];
  logic       busy_v  [2];
  logic       done_v  [2];
  logic       pass_v  [2];
  logic [3:0] mask_v  [2];
  logic [2:0] cnt_v   [2];
  logic [3:0] tbl     [2];

  int compared   = 0;
  int mismatched = 0;

  localparam logic [3:0] EXP0 = 4'b0001;
  localparam logic [3:0] EXP1 = 4'b1000;

  gate_truth_checker u_nor (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .in1(in1_v[0]), .in2(in2_v[0]), .dut_out(dout_v[0]), .vec_idx(vec_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .fail_mask(mask_v[0]), .fail_count(cnt_v[0])
  );

  gate_truth_checker #(.EXPECTED(EXP1), .SETTLE_CYCLES(0)) u_and (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .in1(in1_v[1]), .in2(in2_v[1]), .dut_out(dout_v[1]), .vec_idx(vec_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .fail_mask(mask_v[1]), .fail_count(cnt_v[1])
  );

  // Gate under test: combinational lookup of its own truth table
  assign dout_v[0] = tbl[0][{in1_v[0], in2_v[0]}];
  assign dout_v[1] = tbl[1][{in1_v[1], in2_v[1]}];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int settle_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic logic [3:0] exp_of(input int i);
    return (i == 0) ? EXP0 : EXP1;
  endfunction

  task automatic chk_idle_zero(input int i, input string tag);
    chk({tag, ".busy"}, 32'(busy_v[i]), 0);
    chk({tag, ".done"}, 32'(done_v[i]), 0);
    chk({tag, ".pass"}, 32'(pass_v[i]), 0);
    chk({tag, ".in"}, 32'({in1_v[i], in2_v[i]}), 0);
    chk({tag, ".vec"}, 32'(vec_v[i]), 0);
    chk({tag, ".mask"}, 32'(mask_v[i]), 0);
    chk({tag, ".count"}, 32'(cnt_v[i]), 0);
  endtask

  // Full run with gate table t; optional re-start at cycle restart_at (ignored by DUT)
  task automatic run(input int i, input logic [3:0] t, input int restart_at);
    logic [3:0] em;
    int per, lat, n;
    tbl[i] = t;
    em  = t ^ exp_of(i);
    per = settle_of(i) + 2;
    lat = 4 * per;
    start_v[i] = 1'b1;
    step();
    start_v[i] = 1'b0;
    chk("start.busy", 32'(busy_v[i]), 1);
    chk("start.done_clr", 32'(done_v[i]), 0);
    chk("start.mask_clr", 32'(mask_v[i]), 0);
    n = 0;
    while (!done_v[i] && n < 200) begin
      chk("run.vec", 32'(vec_v[i]), 32'(n / per));
      chk("run.in", 32'({in1_v[i], in2_v[i]}), 32'(n / per));
      start_v[i] = (n == restart_at);
      step();
      start_v[i] = 1'b0;
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("done", 32'(done_v[i]), 1);
    chk("busy", 32'(busy_v[i]), 0);
    chk("pass", 32'(pass_v[i]), 32'(em == 4'd0));
    chk("mask", 32'(mask_v[i]), 32'(em));
    chk("count", 32'(cnt_v[i]), 32'($countones(em)));
    chk("end.in", 32'({in1_v[i], in2_v[i], vec_v[i]}), 0);
    // Results must hold in DONE
    step(); step();
    chk("hold.mask", 32'(mask_v[i]), 32'(em));
    chk("hold.done", 32'(done_v[i]), 1);
  endtask

  initial begin
    logic [3:0] r;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
    end
    tbl[0] = EXP0;
    tbl[1] = EXP1;
    #12;
    chk_idle_zero(0, "reset");
    chk_idle_zero(1, "reset1");
    rst_n = 1'b1;
    step();

    // Correct NOR, stuck-at-0, stuck-at-1 (stuck runs back-to-back from DONE)
    run(0, 4'b0001, -1);
    run(0, 4'b0000, -1);
    run(0, 4'b1111, -1);
    run(0, 4'b0001, -1);

    // Start during busy at cycle 5 is ignored
    run(0, 4'b0001, 5);

    // Abort sampled at the edge closing cycle 9 (vec_idx=2)
    tbl[0] = 4'b1111;
    start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
    for (int k = 0; k < 8; k++) step();
    chk("abort.pre_vec", 32'(vec_v[0]), 2);
    abort_v[0] = 1'b1; step(); abort_v[0] = 1'b0;
    chk_idle_zero(0, "abort");
    step(); step();
    chk("abort.stay_idle", 32'(busy_v[0]), 0);
    run(0, 4'b0001, -1);

    // Abort in DONE keeps results; start+abort in DONE starts a run
    run(0, 4'b0000, -1);
    abort_v[0] = 1'b1; step(); abort_v[0] = 1'b0;
    chk("done_abort.mask", 32'(mask_v[0]), 1);
    chk("done_abort.done", 32'(done_v[0]), 1);
    start_v[0] = 1'b1; abort_v[0] = 1'b1; step();
    start_v[0] = 1'b0; abort_v[0] = 1'b0;
    chk("start_wins.busy", 32'(busy_v[0]), 1);
    chk("start_wins.mask", 32'(mask_v[0]), 0);
    for (int k = 0; k < 20; k++) step();
    chk("start_wins.done", 32'(done_v[0]), 1);

    // Asynchronous reset between edges mid-run
    tbl[0] = 4'b0000;
    start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
    for (int k = 0; k < 6; k++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_zero(0, "async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run(0, 4'b0001, -1);

    // Zero-settle AND instance: correct AND, then NOR model
    run(1, 4'b1000, -1);
    run(1, 4'b0001, -1);

    // Randomized gate tables on both instances
    for (int k = 0; k < 12; k++) begin
      r = 4'($urandom);
      run(k % 2, r, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
